// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache.
// A hit answers in the request cycle. A miss runs a single-request fill, which
// can also forward the returning word to the fetch port in its completion cycle.
module icache_direct #(
  parameter int SETS = 16,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  input  logic            flush,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [31:0]         r_fill_addr;
  logic                r_flush_pend;
  logic [SETS-1:0]     r_valid;
  logic [TAGW-1:0]     r_tag  [SETS];
  logic [31:0]         r_data [SETS];
  logic [CNTW-1:0]     r_hit_count;
  logic [CNTW-1:0]     r_miss_count;

  logic [IDXW-1:0]     w_idx;
  logic [TAGW-1:0]     w_tag;
  logic [IDXW-1:0]     w_fill_idx;
  logic                w_hit;
  logic                w_miss;
  logic                w_start_fill;
  logic                w_count_hit;
  logic                w_write_line;
  logic                w_unused_low_bits;

  // Byte offset bits of the fetch address carry no information for a word cache.
  assign w_unused_low_bits = ^imemaddr[1:0];

  assign w_idx      = imemaddr[IDXW+1:2];
  assign w_tag      = imemaddr[31:IDXW+2];
  assign w_fill_idx = r_fill_addr[IDXW+1:2];
  assign w_hit      = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss     = imemREN & ~w_hit & ~flush;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // FSM state register; reset abandons any pending fill at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a miss opens a fill, an unstalled memory cycle closes it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (iwait) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: fetch response, fill request and internal update strobes.
  always_comb begin
    ihit         = 1'b0;
    imemload     = 32'h0000_0000;
    iREN         = 1'b0;
    iaddr        = 32'h0000_0000;
    w_start_fill = 1'b0;
    w_count_hit  = 1'b0;
    w_write_line = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit && !flush) begin
          ihit        = 1'b1;
          imemload    = r_data[w_idx];
          w_count_hit = 1'b1;
        end else if (w_miss) begin
          w_start_fill = 1'b1;
        end else begin
          ihit = 1'b0;
        end
      end
      ST_FILL: begin
        iREN  = 1'b1;
        iaddr = r_fill_addr;
        if (!iwait) begin
          // A flush seen at any point of the fill leaves the line invalid.
          w_write_line = ~flush & ~r_flush_pend;
          if (imemREN && (imemaddr[31:2] == r_fill_addr[31:2])) begin
            ihit     = 1'b1;
            imemload = iload;
          end else begin
            ihit = 1'b0;
          end
        end else begin
          w_write_line = 1'b0;
        end
      end
      default: begin
        ihit = 1'b0;
      end
    endcase
  end

  // Fill address latch and flush memory for the fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fill_addr  <= 32'h0000_0000;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_start_fill) begin
        r_fill_addr <= {imemaddr[31:2], 2'b00};
      end
      if (r_state == ST_FILL) begin
        if (!iwait) begin
          r_flush_pend <= 1'b0;
        end else if (flush) begin
          r_flush_pend <= 1'b1;
        end
      end else begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  // Valid bits: flush invalidates everything, a completed fill validates its set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= {SETS{1'b0}};
    end else if (flush) begin
      r_valid <= {SETS{1'b0}};
    end else if (w_write_line) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents only matter where the valid bit is set.
  always_ff @(posedge CLK) begin
    if (w_write_line) begin
      r_tag[w_fill_idx]  <= r_fill_addr[31:IDXW+2];
      r_data[w_fill_idx] <= iload;
    end
  end

  // Performance counters for CPI measurement; both wrap naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= {CNTW{1'b0}};
      r_miss_count <= {CNTW{1'b0}};
    end else begin
      if (w_count_hit) begin
        r_hit_count <= r_hit_count + {{(CNTW-1){1'b0}}, 1'b1};
      end
      if (w_start_fill) begin
        r_miss_count <= r_miss_count + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
